demux1to2_nbits_stream: RTL and testbench
=========================================

Name: demux1to2_nbits_stream

Overview:
Registered 1:2 stream demultiplexer, the splitting counterpart of the team's 2:1 mux. It accepts one SIZE-bit word per handshake and routes it to output A when in_sel=1 or output B when in_sel=0, matching the mux select polarity. Each output has a one-entry holding register with valid/ready flow control and a per-output delivered-word counter. It sits wherever a single producer feeds two downstream consumers.

Parameters:
SIZE, 4, width of data words on input and both outputs
CNT_W, 8, width of each per-output delivered-word counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
in_data  input  SIZE  word to route
in_sel  input  1  1 = route to A, 0 = route to B
in_valid  input  1  producer has a word on in_data/in_sel
in_ready  output  1  block accepts the word this cycle
a_data  output  SIZE  output A word
a_valid  output  1  output A holds a word
a_ready  input  1  consumer A takes the word this cycle
b_data  output  SIZE  output B word
b_valid  output  1  output B holds a word
b_ready  input  1  consumer B takes the word this cycle
a_count  output  CNT_W  words delivered on A since reset
b_count  output  CNT_W  words delivered on B since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset (reset_n=0 at a clk edge): a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0.
  - Reset mid-operation discards any held words without delivering them.
  - in_ready is don't-care during reset; the producer must not count a transfer while reset_n=0.
- Slot state: each output slot is one register plus a valid flag. It is empty when valid=0.
- in_ready (combinational):
  - in_sel=1: in_ready = !a_valid || a_ready.
  - in_sel=0: in_ready = !b_valid || b_ready.
  - in_ready depends on in_sel and the selected ready only. There is no path from in_valid to in_ready.
- Input transfer: in_valid && in_ready at a clk edge. The selected slot loads in_data and its valid is set to 1 on that edge, so latency is 1 cycle. The non-selected slot is unaffected.
- Output transfer: x_valid && x_ready at a clk edge. x_valid clears unless the same slot is reloaded on that edge.
- Simultaneous drain and load of the same slot: the slot stays valid, holds the new word, and its count increments. This gives back-to-back throughput of 1 word/cycle per output.
- Simultaneous activity on both outputs: A and B drain independently in the same cycle. Both counters may increment together.
- Stability: while x_valid && !x_ready, x_data holds stable.
- Producer rule: while in_valid && !in_ready, the producer holds in_data and in_sel stable.
- Head-of-line blocking: if the selected slot is full and not draining, in_ready=0 even when the other slot is empty. Words are never reordered or redirected.
- Counters: a_count and b_count increment by 1 on each output transfer. They wrap modulo 2^CNT_W, so 2^CNT_W-1 is followed by 0, with no saturation and no flag.
- No combinational path from in_data to any output; all x_data and x_valid come from registers.

Decomposition:
- Shared package demux_pkg: enum port_sel_t with SEL_B=1'b0 and SEL_A=1'b1.
- Sub-module demux_slot (params SIZE, CNT_W), instantiated twice:
  - holds data, valid and count;
  - inputs: load, load_data, drain_ready;
  - outputs: data, valid, count, can_accept.
- Top level:
  - decodes in_sel to the two slot load strobes (load_x = in_valid && in_ready && selected);
  - muxes can_accept into in_ready.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with in_valid=1 -> a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0 after the edge.
- Basic routing: with a_ready=b_ready=1, send 4'hA (sel=1) then 4'h5 (sel=0) -> a_data=4'hA, a_valid=1 one cycle after the first transfer; b_data=4'h5 one cycle after the second; a_count=1, b_count=1.
- Backpressure: b_ready=0, send 4'h3 (sel=0), then present 4'h7 (sel=0) -> in_ready=0 and b_data holds 4'h3. Raise b_ready -> 4'h7 loads the same cycle 4'h3 drains, and b_count increments per drained word.
- Head-of-line: A full with a_ready=0, present sel=1 -> in_ready=0 while B is empty. Switch to sel=0 -> in_ready=1 and the word goes to B.
- Streaming: a_ready=1, send 16 consecutive words 0..F with sel=1 -> 1 word/cycle, in order on A, a_count=16, b_valid stays 0.
- Wrap and reset mid-flight: CNT_W=2, deliver 5 words on A -> a_count=1. Assert reset_n=0 while a_valid=1 -> a_valid=0 and a_count=0, with no extra delivery.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 stream demultiplexer.
// Select polarity matches the 2:1 mux: 1 routes to A, 0 routes to B.
package demux_pkg;

    typedef enum logic {
        SEL_B = 1'b0,
        SEL_A = 1'b1
    } port_sel_t;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready flow control
// and a wrapping count of words delivered downstream.
module demux_slot #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [SIZE-1:0]  load_data,
    input  logic             drain_ready,
    output logic [SIZE-1:0]  data,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             can_accept
);

    logic [SIZE-1:0]  data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain_s;

    assign drain_s    = valid_q && drain_ready;
    assign can_accept = !valid_q || drain_ready;

    // Next-state: a load wins over a drain so back-to-back words keep the slot full
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (drain_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (drain_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Slot state registers; reset discards any held word
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= {SIZE{1'b0}};
            valid_q <= 1'b0;
            count_q <= {CNT_W{1'b0}};
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule : demux_slot

// File: rtl/demux1to2_nbits_stream.sv
// Registered 1:2 stream demultiplexer: one producer feeding two consumers,
// each behind its own one-entry slot. No reordering or redirection of words.
module demux1to2_nbits_stream
    import demux_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SIZE-1:0]  in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SIZE-1:0]  a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [SIZE-1:0]  b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    port_sel_t sel_s;
    logic      a_can_s, b_can_s;
    logic      in_ready_s;
    logic      load_a_s, load_b_s;

    assign sel_s = port_sel_t'(in_sel);

    // Ready follows only the selected slot, giving head-of-line blocking
    always_comb begin
        in_ready_s = 1'b0;
        load_a_s   = 1'b0;
        load_b_s   = 1'b0;
        case (sel_s)
            SEL_A: begin
                in_ready_s = a_can_s;
                load_a_s   = in_valid && a_can_s;
            end
            SEL_B: begin
                in_ready_s = b_can_s;
                load_b_s   = in_valid && b_can_s;
            end
            default: begin
                in_ready_s = 1'b0;
                load_a_s   = 1'b0;
                load_b_s   = 1'b0;
            end
        endcase
    end

    assign in_ready = in_ready_s;

    demux_slot #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load_a_s),
        .load_data   (in_data),
        .drain_ready (a_ready),
        .data        (a_data),
        .valid       (a_valid),
        .count       (a_count),
        .can_accept  (a_can_s)
    );

    demux_slot #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load_b_s),
        .load_data   (in_data),
        .drain_ready (b_ready),
        .data        (b_data),
        .valid       (b_valid),
        .count       (b_count),
        .can_accept  (b_can_s)
    );

endmodule : demux1to2_nbits_stream

// File: tb/tb_demux1to2_nbits_stream.sv
// Directed bench with a per-output scoreboard for the 1:2 stream demux,
// plus a narrow-counter instance for wrap and mid-flight reset.
module tb_demux1to2_nbits_stream;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_data;
    logic       in_sel, in_valid, in_ready;
    logic [3:0] a_data, b_data;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [7:0] a_count, b_count;

    logic       w_reset_n;
    logic [3:0] w_in_data;
    logic       w_in_sel, w_in_valid, w_in_ready;
    logic [3:0] w_a_data, w_b_data;
    logic       w_a_valid, w_a_ready, w_b_valid, w_b_ready;
    logic [1:0] w_a_count, w_b_count;

    int passed = 0;
    int total  = 0;
    int exp_a_cnt = 0;
    int exp_b_cnt = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    always #5 clk = ~clk;

    demux1to2_nbits_stream #(.SIZE(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_count(a_count), .b_count(b_count)
    );

    demux1to2_nbits_stream #(.SIZE(4), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset_n(w_reset_n),
        .in_data(w_in_data), .in_sel(w_in_sel), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a_data(w_a_data), .a_valid(w_a_valid), .a_ready(w_a_ready),
        .b_data(w_b_data), .b_valid(w_b_valid), .b_ready(w_b_ready),
        .a_count(w_a_count), .b_count(w_b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes seen at negedge complete on the following rising edge
    always @(negedge clk) begin
        if (!reset_n) begin
            qa.delete();
            qb.delete();
            exp_a_cnt = 0;
            exp_b_cnt = 0;
        end else begin
            check("a_valid", {31'd0, a_valid}, {31'd0, (qa.size() != 0)});
            check("b_valid", {31'd0, b_valid}, {31'd0, (qb.size() != 0)});
            if (in_sel)
                check("in_ready_a", {31'd0, in_ready}, {31'd0, (qa.size() == 0) || a_ready});
            else
                check("in_ready_b", {31'd0, in_ready}, {31'd0, (qb.size() == 0) || b_ready});
            if (a_valid && qa.size() != 0) check("a_data", {28'd0, a_data}, {28'd0, qa[0]});
            if (b_valid && qb.size() != 0) check("b_data", {28'd0, b_data}, {28'd0, qb[0]});
            if (a_valid && a_ready && qa.size() != 0) begin
                void'(qa.pop_front());
                exp_a_cnt = exp_a_cnt + 1;
            end
            if (b_valid && b_ready && qb.size() != 0) begin
                void'(qb.pop_front());
                exp_b_cnt = exp_b_cnt + 1;
            end
            if (in_valid && in_ready) begin
                if (in_sel) qa.push_back(in_data);
                else        qb.push_back(in_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; in_data = 4'hF; in_sel = 1'b1; in_valid = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        w_reset_n = 1'b0; w_in_data = 4'h0; w_in_sel = 1'b1; w_in_valid = 1'b0;
        w_a_ready = 1'b1; w_b_ready = 1'b1;

        // Reset with the producer still presenting a word
        step(); step();
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_a_data", {28'd0, a_data}, 32'd0);
        check("rst_b_data", {28'd0, b_data}, 32'd0);
        check("rst_a_count", {24'd0, a_count}, 32'd0);
        check("rst_b_count", {24'd0, b_count}, 32'd0);

        // Basic routing
        reset_n = 1'b1; in_data = 4'hA; in_sel = 1'b1; in_valid = 1'b1;
        step();
        check("route_a_valid", {31'd0, a_valid}, 32'd1);
        check("route_a_data", {28'd0, a_data}, 32'hA);
        in_data = 4'h5; in_sel = 1'b0;
        step();
        check("route_b_data", {28'd0, b_data}, 32'h5);
        in_valid = 1'b0;
        step();
        check("route_a_count", {24'd0, a_count}, 32'd1);
        check("route_b_count", {24'd0, b_count}, 32'd1);

        // Backpressure on B, then drain and reload in the same cycle
        b_ready = 1'b0; in_data = 4'h3; in_sel = 1'b0; in_valid = 1'b1;
        step();
        in_data = 4'h7;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_b_hold", {28'd0, b_data}, 32'h3);
        b_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_b_reload", {28'd0, b_data}, 32'h7);
        check("bp_b_valid", {31'd0, b_valid}, 32'd1);
        check("bp_b_count2", {24'd0, b_count}, 32'd2);
        in_valid = 1'b0;
        step();
        check("bp_b_count3", {24'd0, b_count}, 32'd3);

        // Head-of-line blocking with B empty
        a_ready = 1'b0; in_data = 4'h9; in_sel = 1'b1; in_valid = 1'b1;
        step();
        in_data = 4'hC;
        #1;
        check("hol_in_ready", {31'd0, in_ready}, 32'd0);
        check("hol_b_empty", {31'd0, b_valid}, 32'd0);
        step();
        check("hol_a_hold", {28'd0, a_data}, 32'h9);
        in_sel = 1'b0;
        #1;
        check("hol_switch_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("hol_b_data", {28'd0, b_data}, 32'hC);
        in_valid = 1'b0; a_ready = 1'b1;
        step();
        check("hol_a_count", {24'd0, a_count}, 32'd2);
        check("hol_b_count", {24'd0, b_count}, 32'd4);

        // Streaming 16 words on A
        in_sel = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 4'(i);
            step();
            check("stream_a_data", {28'd0, a_data}, i);
        end
        in_valid = 1'b0;
        step();
        check("stream_a_count", {24'd0, a_count}, 32'd18);
        check("stream_a_model", {24'd0, a_count}, exp_a_cnt);
        check("stream_b_model", {24'd0, b_count}, exp_b_cnt);
        check("stream_b_idle", {31'd0, b_valid}, 32'd0);

        // Narrow counter wrap, then reset while a word is held
        w_reset_n = 1'b1; w_in_sel = 1'b1; w_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_in_data = 4'(i + 1);
            step();
        end
        w_in_valid = 1'b0;
        step();
        check("wrap_a_count", {30'd0, w_a_count}, 32'd1);
        check("wrap_b_count", {30'd0, w_b_count}, 32'd0);
        w_a_ready = 1'b0; w_in_data = 4'hE; w_in_valid = 1'b1;
        step();
        w_in_valid = 1'b0;
        check("wrap_held", {31'd0, w_a_valid}, 32'd1);
        check("wrap_held_data", {28'd0, w_a_data}, 32'hE);
        w_a_ready = 1'b1; w_reset_n = 1'b0;
        step();
        check("midrst_a_valid", {31'd0, w_a_valid}, 32'd0);
        check("midrst_a_count", {30'd0, w_a_count}, 32'd0);
        w_reset_n = 1'b1;
        step();
        check("midrst_no_deliver", {30'd0, w_a_count}, 32'd0);
        check("midrst_b_valid", {31'd0, w_b_valid}, 32'd0);
        check("midrst_b_data", {28'd0, w_b_data}, 32'd0);
        check("midrst_in_ready", {31'd0, w_in_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_demux1to2_nbits_stream
